target_port: RTL and testbench
==============================

// Module: target_port
// PURPOSE
//  Serial-bus-side front end of a bus target. Deserialises a request frame from the bus
//  into one parallel transaction toward the target memory block (addr/data/rw valid pulses),
//  waits for its ack, and serialises read data back onto the bus. Sits directly upstream
//  of the target, one instance per target.
// PARAMETERS
//  ADDR_WIDTH      16  address bits in a frame (drives target_addr_in width)
//  DATA_WIDTH      8   data bits per write/read beat
//  TIMEOUT_CYCLES  16  max cycles from issue to target_ack before error (>=2)
// PORTS
//  clk                    in   1           system clock, rising edge
//  rst_n                  in   1           asynchronous active-low reset
//  bus_sel                in   1           level: this target addressed by bus; low aborts frame
//  bus_wdata              in   1           serial request bit
//  bus_wvalid             in   1           bus_wdata valid this cycle (gaps allowed)
//  bus_rdata              out  1           serial read-data bit
//  bus_rvalid             out  1           bus_rdata valid this cycle
//  bus_done               out  1           1-cycle pulse: transaction completed
//  bus_err                out  1           1-cycle pulse: target timeout
//  target_addr_in         out  ADDR_WIDTH  registered address to target
//  target_addr_in_valid   out  1           1-cycle issue pulse
//  target_data_in         out  DATA_WIDTH  registered write data
//  target_data_in_valid   out  1           1-cycle, only with write issue
//  target_rw              out  1           1=write, 0=read; held with address
//  target_data_out        in   DATA_WIDTH  read data from target
//  target_data_out_valid  in   1           read data valid
//  target_ack             in   1           target completed transaction
//  target_ready           in   1           target can accept an issue
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, bit counter 0, timeout counter 0.
//  Frame (bits counted only when bus_sel && bus_wvalid): rw bit first, then ADDR_WIDTH
//   address bits LSB first, then for writes DATA_WIDTH data bits LSB first.
//  States: IDLE -> RX_ADDR -> [RX_DATA if rw=1] -> ISSUE -> WAIT_ACK -> [TX_DATA if read] -> IDLE.
//  IDLE: first valid bit latched as rw, go RX_ADDR.
//  RX_ADDR/RX_DATA: shift in; leave on the cycle the last bit is sampled.
//  ISSUE: when target_ready=1, pulse target_addr_in_valid for exactly 1 cycle with
//   target_addr_in/target_rw stable; writes also pulse target_data_in_valid same cycle.
//   target_ready=0 holds in ISSUE. Go WAIT_ACK after the pulse.
//  WAIT_ACK: on target_ack: write -> bus_done pulse next cycle, IDLE; read -> capture
//   target_data_out (requires target_data_out_valid same cycle; ack without valid on a read
//   is treated as ack with data 0), go TX_DATA. Ack in the same cycle as the issue pulse ignored.
//  TX_DATA: DATA_WIDTH consecutive cycles, bus_rvalid=1, bus_rdata = captured bit i, LSB
//   first, no gaps; bus_done pulses with the last bit; then IDLE.
//  Timeout: counter clears on ISSUE entry, increments each cycle in ISSUE/WAIT_ACK; on
//   reaching TIMEOUT_CYCLES without ack: bus_err pulse 1 cycle, IDLE, no bus_done.
//  bus_sel=0 in RX_ADDR/RX_DATA: abort to IDLE next cycle, no issue, no done/err.
//  bus_sel=0 in ISSUE/WAIT_ACK/TX_DATA: ignored; transaction completes (target already committed).
//  bus_wvalid outside RX states ignored (no buffering of next frame).
//  bus_done and bus_err never assert in the same cycle; at most one issue per frame.
//  Async reset mid-operation: immediate return to reset values, pending transaction dropped.
// TESTING
//  Write rw=1, addr 0x0005, data 0xA5 (25 bits, no gaps), ack 1 cycle after issue ->
//   one cycle addr_valid=data_valid=1, addr=0x0005, data=0xA5, rw=1; bus_done 1 cycle after ack.
//  Read addr 0x0003, target returns 0x3C with ack+valid -> bus_rdata 0,0,1,1,1,1,0,0 on 8
//   consecutive rvalid cycles; bus_done with 8th bit.
//  Write with bus_wvalid low every other cycle -> identical issue values as gap-free case.
//  bus_sel dropped after 7 address bits -> no addr_valid; next full frame decodes correctly.
//  TIMEOUT_CYCLES=8, ack held 0 -> bus_err exactly 8 cycles after ISSUE entry, no bus_done;
//   target_ready held 0 for 3 cycles before issue -> issue delayed 3 cycles, still acked OK.
//  rst_n asserted during TX_DATA bit 4 -> bus_rvalid=0 immediately; next read frame clean.

Source files
------------

// File: rtl/target_port.sv
// ----------------------------------------------------------------------------
// target_port
//
// Bus-side front end of one bus target. A request frame arrives one bit at a
// time (rw bit, then the address LSB first, then write data LSB first). The
// frame becomes a single parallel issue toward the target memory block. The
// port then waits for the target's ack. Read data comes back serially, LSB
// first, on consecutive cycles.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   bus_sel                level select from the bus; low during reception aborts
//   bus_wdata, bus_wvalid  serial request bit and its qualifier (gaps allowed)
//   bus_rdata, bus_rvalid  serial read data and its qualifier
//   bus_done, bus_err      one-cycle completion / target-timeout pulses
//   target_addr_in         registered address toward the target
//   target_addr_in_valid   one-cycle issue pulse
//   target_data_in         registered write data
//   target_data_in_valid   one-cycle pulse, write issues only
//   target_rw              1 = write, 0 = read
//   target_data_out        read data from the target
//   target_data_out_valid  read data qualifier
//   target_ack             target finished the transaction
//   target_ready           target can accept an issue this cycle
// ----------------------------------------------------------------------------
module target_port #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_sel,
  input  logic                  bus_wdata,
  input  logic                  bus_wvalid,
  output logic                  bus_rdata,
  output logic                  bus_rvalid,
  output logic                  bus_done,
  output logic                  bus_err,
  output logic [ADDR_WIDTH-1:0] target_addr_in,
  output logic                  target_addr_in_valid,
  output logic [DATA_WIDTH-1:0] target_data_in,
  output logic                  target_data_in_valid,
  output logic                  target_rw,
  input  logic [DATA_WIDTH-1:0] target_data_out,
  input  logic                  target_data_out_valid,
  input  logic                  target_ack,
  input  logic                  target_ready
);

  // One bit counter is shared by address, write-data and read-data phases.
  localparam int CNT_MAX = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    RX_ADDR,
    RX_DATA,
    ISSUE,
    WAIT_ACK,
    TX_DATA
  } state_t;

  state_t state;
  state_t state_next;

  logic                  rw_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [CNT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic                  done_q;
  logic                  err_q;

  logic bit_in;
  logic last_addr_bit;
  logic last_data_bit;
  logic last_tx_bit;
  logic timeout_hit;
  logic issue;
  logic done_set;
  logic err_set;

  assign bit_in        = bus_sel && bus_wvalid;
  assign last_addr_bit = (bit_cnt == ADDR_LAST);
  assign last_data_bit = (bit_cnt == DATA_LAST);
  assign last_tx_bit   = (bit_cnt == DATA_LAST);
  // The counter saturates, so >= also covers an issue granted on the last
  // allowed cycle that then gets no ack.
  assign timeout_hit   = (to_cnt >= TO_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, plus the issue strobe and the done/err set terms.
  // Leaving ISSUE happens in the issue cycle itself, so an ack that arrives
  // together with the issue pulse is never seen by WAIT_ACK.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (bit_in) begin
          state_next = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (!bus_sel) begin
          state_next = IDLE;
        end else if (bus_wvalid && last_addr_bit) begin
          state_next = rw_q ? RX_DATA : ISSUE;
        end
      end
      RX_DATA: begin
        if (!bus_sel) begin
          state_next = IDLE;
        end else if (bus_wvalid && last_data_bit) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (target_ready) begin
          issue      = 1'b1;
          state_next = WAIT_ACK;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      WAIT_ACK: begin
        if (target_ack) begin
          done_set   = rw_q;
          state_next = rw_q ? IDLE : TX_DATA;
        end else if (timeout_hit) begin
          err_set    = 1'b1;
          state_next = IDLE;
        end
      end
      TX_DATA: begin
        if (last_tx_bit) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: frame shift registers, bit counter, timeout counter, read-data
  // shifter and the registered done/err pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      tx_shift <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= done_set;
      err_q  <= err_set;

      if ((state_next == ISSUE) && (state != ISSUE)) begin
        to_cnt <= '0;
      end else if (((state == ISSUE) || (state == WAIT_ACK)) && !timeout_hit) begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      case (state)
        IDLE: begin
          if (bit_in) begin
            rw_q    <= bus_wdata;
            bit_cnt <= '0;
          end
        end
        RX_ADDR: begin
          // LSB arrives first, so shift in from the top.
          if (bit_in) begin
            addr_q  <= {bus_wdata, addr_q[ADDR_WIDTH-1:1]};
            bit_cnt <= last_addr_bit ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (bit_in) begin
            data_q  <= {bus_wdata, data_q[DATA_WIDTH-1:1]};
            bit_cnt <= last_data_bit ? '0 : bit_cnt + CNT_W'(1);
          end
        end
        WAIT_ACK: begin
          // A read ack without data valid returns zero data.
          if (target_ack && !rw_q) begin
            tx_shift <= target_data_out_valid ? target_data_out : '0;
            bit_cnt  <= '0;
          end
        end
        TX_DATA: begin
          tx_shift <= tx_shift >> 1;
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign target_addr_in       = addr_q;
  assign target_data_in       = data_q;
  assign target_rw            = rw_q;
  assign target_addr_in_valid = issue;
  assign target_data_in_valid = issue && rw_q;

  // Read data is driven straight from state so a reset drops rvalid at once.
  assign bus_rvalid = (state == TX_DATA);
  assign bus_rdata  = (state == TX_DATA) && tx_shift[0];
  assign bus_done   = done_q || ((state == TX_DATA) && last_tx_bit);
  assign bus_err    = err_q;

endmodule

// File: tb/tb_target_port.sv
// ----------------------------------------------------------------------------
// tb_target_port
//
// Directed bench for target_port (ADDR 16, DATA 8, TIMEOUT 8). The stimulus
// pushes the expected target issues and bus completion events into queues. A
// negedge monitor pops them when the DUT produces an issue or a done/err pulse.
// Cycle-exact timing is checked inline by the stimulus.
// ----------------------------------------------------------------------------
module tb_target_port;

  localparam int ADDR_WIDTH     = 16;
  localparam int DATA_WIDTH     = 8;
  localparam int TIMEOUT_CYCLES = 8;

  localparam int EV_WRITE = 0;
  localparam int EV_READ  = 1;
  localparam int EV_ERR   = 2;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } issue_t;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } event_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bus_sel;
  logic        bus_wdata;
  logic        bus_wvalid;
  logic        bus_rdata;
  logic        bus_rvalid;
  logic        bus_done;
  logic        bus_err;
  logic [15:0] target_addr_in;
  logic        target_addr_in_valid;
  logic [7:0]  target_data_in;
  logic        target_data_in_valid;
  logic        target_rw;
  logic [7:0]  target_data_out;
  logic        target_data_out_valid;
  logic        target_ack;
  logic        target_ready;

  issue_t exp_issue_q[$];
  event_t exp_ev_q[$];

  int checks = 0;
  int errors = 0;

  issue_t     mon_it;
  event_t     mon_ev;
  logic [7:0] rx_byte;
  int         rx_n;
  int         k;

  target_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_sel(bus_sel),
    .bus_wdata(bus_wdata),
    .bus_wvalid(bus_wvalid),
    .bus_rdata(bus_rdata),
    .bus_rvalid(bus_rvalid),
    .bus_done(bus_done),
    .bus_err(bus_err),
    .target_addr_in(target_addr_in),
    .target_addr_in_valid(target_addr_in_valid),
    .target_data_in(target_data_in),
    .target_data_in_valid(target_data_in_valid),
    .target_rw(target_rw),
    .target_data_out(target_data_out),
    .target_data_out_valid(target_data_out_valid),
    .target_ack(target_ack),
    .target_ready(target_ready)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_event(input int kind, input logic [7:0] data);
    event_t ev;
    ev.kind = kind;
    ev.data = data;
    exp_ev_q.push_back(ev);
  endtask

  task automatic send_bit(input logic b, input bit gap);
    if (gap) begin
      bus_wvalid = 1'b0;
      tick();
    end
    bus_wdata  = b;
    bus_wvalid = 1'b1;
    tick();
    bus_wvalid = 1'b0;
    bus_wdata  = 1'b0;
  endtask

  // Sends one full frame and records the issue it must produce. On return the
  // DUT is in its first ISSUE cycle; bus_sel is dropped there on purpose.
  task automatic apply_stimulus(input logic rw, input logic [15:0] addr,
                                input logic [7:0] data, input bit gaps);
    issue_t it;
    it.rw   = rw;
    it.addr = addr;
    it.data = data;
    exp_issue_q.push_back(it);
    bus_sel = 1'b1;
    send_bit(rw, 1'b0);
    for (int i = 0; i < 16; i++) send_bit(addr[i], gaps);
    if (rw) begin
      for (int i = 0; i < 8; i++) send_bit(data[i], gaps);
    end
    bus_sel = 1'b0;
  endtask

  // Called in a WAIT_ACK cycle: ack a write, done must follow one cycle later.
  task automatic ack_write();
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    check_bit("write_done_after_ack", bus_done, 1'b1);
    check_bit("write_no_err", bus_err, 1'b0);
    tick();
    check_bit("write_done_single", bus_done, 1'b0);
  endtask

  // Called in a WAIT_ACK cycle: ack a read with the given data/valid.
  task automatic respond_read(input logic [7:0] d, input logic dv);
    target_ack            = 1'b1;
    target_data_out       = d;
    target_data_out_valid = dv;
    tick();
    target_ack            = 1'b0;
    target_data_out       = 8'h00;
    target_data_out_valid = 1'b0;
  endtask

  task automatic read_bits(input logic [7:0] expected);
    for (int i = 0; i < 8; i++) begin
      check_bit("read_rvalid", bus_rvalid, 1'b1);
      check_bit("read_bit", bus_rdata, expected[i]);
      check_bit("read_done", bus_done, (i == 7));
      tick();
    end
    check_bit("read_rvalid_end", bus_rvalid, 1'b0);
    check_bit("read_done_end", bus_done, 1'b0);
  endtask

  // Scoreboard monitor: compares issues and done/err pulses against queues.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_n    = 0;
      rx_byte = 8'h00;
    end else begin
      if (target_addr_in_valid) begin
        if (exp_issue_q.size() == 0) begin
          check_bit("issue_expected", target_addr_in_valid, 1'b0);
        end else begin
          mon_it = exp_issue_q.pop_front();
          check_output("issue_addr", 32'(target_addr_in), 32'(mon_it.addr));
          check_bit("issue_rw", target_rw, mon_it.rw);
          check_bit("issue_data_valid", target_data_in_valid, mon_it.rw);
          if (mon_it.rw) check_output("issue_data", 32'(target_data_in), 32'(mon_it.data));
        end
      end
      if (bus_rvalid) begin
        rx_byte = {bus_rdata, rx_byte[7:1]};
        rx_n++;
      end
      if (bus_done || bus_err) begin
        check_bit("done_err_exclusive", bus_done && bus_err, 1'b0);
        if (exp_ev_q.size() == 0) begin
          check_bit("event_expected", bus_done || bus_err, 1'b0);
        end else begin
          mon_ev = exp_ev_q.pop_front();
          check_output("event_kind",
                       bus_err ? EV_ERR : (bus_rvalid ? EV_READ : EV_WRITE), mon_ev.kind);
          if (mon_ev.kind == EV_READ) begin
            check_output("read_bit_count", rx_n, 8);
            check_output("read_byte", 32'(rx_byte), 32'(mon_ev.data));
          end
        end
        rx_n = 0;
      end
    end
  end

  initial begin
    rst_n                 = 1'b1;
    bus_sel               = 1'b0;
    bus_wdata             = 1'b0;
    bus_wvalid            = 1'b0;
    target_data_out       = 8'h00;
    target_data_out_valid = 1'b0;
    target_ack            = 1'b0;
    target_ready          = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) tick();

    $display("[TB] reset values");
    check_bit("rst_rvalid", bus_rvalid, 1'b0);
    check_bit("rst_rdata", bus_rdata, 1'b0);
    check_bit("rst_done", bus_done, 1'b0);
    check_bit("rst_err", bus_err, 1'b0);
    check_output("rst_addr", 32'(target_addr_in), 32'h0);
    check_bit("rst_addr_valid", target_addr_in_valid, 1'b0);
    check_output("rst_data", 32'(target_data_in), 32'h0);
    check_bit("rst_data_valid", target_data_in_valid, 1'b0);
    check_bit("rst_rw", target_rw, 1'b0);
    rst_n = 1'b1;
    tick();

    $display("[TB] gap-free write 0x0005 <= 0xA5");
    expect_event(EV_WRITE, 8'h00);
    apply_stimulus(1'b1, 16'h0005, 8'hA5, 1'b0);
    check_bit("w_issue", target_addr_in_valid, 1'b1);
    check_bit("w_data_valid", target_data_in_valid, 1'b1);
    tick();
    check_bit("w_issue_single", target_addr_in_valid, 1'b0);
    ack_write();

    $display("[TB] read 0x0003 -> 0x3C");
    expect_event(EV_READ, 8'h3C);
    apply_stimulus(1'b0, 16'h0003, 8'h00, 1'b0);
    check_bit("r_issue", target_addr_in_valid, 1'b1);
    check_bit("r_no_data_valid", target_data_in_valid, 1'b0);
    tick();
    respond_read(8'h3C, 1'b1);
    read_bits(8'h3C);

    $display("[TB] gapped write, ack in issue cycle ignored");
    expect_event(EV_WRITE, 8'h00);
    apply_stimulus(1'b1, 16'h0005, 8'hA5, 1'b1);
    check_bit("g_issue", target_addr_in_valid, 1'b1);
    target_ack = 1'b1;
    tick();
    target_ack = 1'b0;
    tick();
    check_bit("g_no_early_done", bus_done, 1'b0);
    ack_write();

    $display("[TB] abort after 7 address bits, then read 0x1234");
    bus_sel = 1'b1;
    send_bit(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1, 1'b0);
    bus_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bit("abort_no_issue", target_addr_in_valid, 1'b0);
      check_bit("abort_no_done", bus_done, 1'b0);
    end
    expect_event(EV_READ, 8'h5A);
    apply_stimulus(1'b0, 16'h1234, 8'h00, 1'b0);
    check_bit("a_issue", target_addr_in_valid, 1'b1);
    tick();
    respond_read(8'h5A, 1'b1);
    read_bits(8'h5A);

    $display("[TB] read ack without data valid");
    expect_event(EV_READ, 8'h00);
    apply_stimulus(1'b0, 16'h0010, 8'h00, 1'b0);
    tick();
    respond_read(8'hFF, 1'b0);
    read_bits(8'h00);

    $display("[TB] timeout with ack held low");
    expect_event(EV_ERR, 8'h00);
    apply_stimulus(1'b1, 16'h00FF, 8'h11, 1'b0);
    k = 0;
    while (!bus_err && k < 20) begin
      tick();
      k++;
    end
    check_output("timeout_latency", k, 8);
    check_bit("timeout_no_done", bus_done, 1'b0);
    tick();
    check_bit("timeout_err_single", bus_err, 1'b0);
    check_bit("timeout_no_late_done", bus_done, 1'b0);

    $display("[TB] target_ready low for 3 cycles");
    expect_event(EV_WRITE, 8'h00);
    target_ready = 1'b0;
    apply_stimulus(1'b1, 16'hBEEF, 8'h6C, 1'b0);
    check_bit("ready_wait0", target_addr_in_valid, 1'b0);
    tick();
    check_bit("ready_wait1", target_addr_in_valid, 1'b0);
    tick();
    check_bit("ready_wait2", target_addr_in_valid, 1'b0);
    tick();
    target_ready = 1'b1;
    #1;
    check_bit("ready_issue", target_addr_in_valid, 1'b1);
    tick();
    ack_write();

    $display("[TB] reset during read bit 4");
    expect_event(EV_READ, 8'hC3);
    apply_stimulus(1'b0, 16'h0003, 8'h00, 1'b0);
    tick();
    respond_read(8'hC3, 1'b1);
    repeat (4) tick();
    check_bit("pre_reset_rvalid", bus_rvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("reset_rvalid", bus_rvalid, 1'b0);
    check_bit("reset_done", bus_done, 1'b0);
    exp_ev_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    expect_event(EV_READ, 8'h96);
    apply_stimulus(1'b0, 16'h0042, 8'h00, 1'b0);
    check_bit("post_reset_issue", target_addr_in_valid, 1'b1);
    tick();
    respond_read(8'h96, 1'b1);
    read_bits(8'h96);

    repeat (4) tick();
    check_output("issue_queue_drained", exp_issue_q.size(), 0);
    check_output("event_queue_drained", exp_ev_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
